// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: instruction-fetch front end with multiple outstanding
// memory requests and a response FIFO feeding decode.
//
// Sequential fetch requests are issued from fetch_pc, with up to OUTS of them
// in flight. The PC of each accepted request is held in a small PC queue until
// its in-order response returns. The response is then pushed into a DP-deep
// FIFO as {pc, instr, err}. A redirect flushes the FIFO and the PC queue, and
// loads fetch_pc with the target. It also records how many stale responses
// are still owed by memory (kill_cnt) so that they can be dropped on arrival.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge of clk. Valid never depends on ready of the same
// channel. The response channel is always ready, because a request is only
// issued when FIFO space is already reserved for its response.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   jmp_req_i        redirect request; jmp_addr_i is the new fetch target
//   ifu_vld_o        instruction valid to decode; ifu_rdy_i is decode ready
//   ifu_pc_o         PC of the presented instruction
//   ifu_instr_o      presented instruction
//   ifu_err_o        bus error of the presented instruction
//   ifu_req_*        memory request channel (vld/rdy/addr)
//   ifu_rsp_*        memory response channel (vld/rdy/data/err)
module ifu_fetch_queue #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int OUTS = 2,
  parameter int DP = 4,
  parameter int BYPASS = 1,
  parameter logic [AW-1:0] RST_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jmp_req_i,
  input  logic [AW-1:0] jmp_addr_i,
  output logic          ifu_vld_o,
  input  logic          ifu_rdy_i,
  output logic [AW-1:0] ifu_pc_o,
  output logic [DW-1:0] ifu_instr_o,
  output logic          ifu_err_o,
  output logic          ifu_req_vld,
  input  logic          ifu_req_rdy,
  output logic [AW-1:0] ifu_req_addr,
  input  logic          ifu_rsp_vld,
  output logic          ifu_rsp_rdy,
  input  logic [DW-1:0] ifu_rsp_data,
  input  logic          ifu_rsp_err
);

  localparam int CW  = $clog2(DP + 1);
  localparam int PQW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int FPW = (DP > 1) ? $clog2(DP) : 1;
  localparam logic [CW-1:0] OUTS_C = CW'(OUTS);
  localparam logic [CW:0]   DP_C   = (CW + 1)'(DP);

  logic [AW-1:0]  fetch_pc;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  kill_cnt;
  logic [CW-1:0]  fifo_cnt;

  logic [AW-1:0]  pq_mem [OUTS];
  logic [PQW-1:0] pq_wp, pq_rp;

  logic [AW-1:0]  f_pc    [DP];
  logic [DW-1:0]  f_instr [DP];
  logic           f_err   [DP];
  logic [FPW-1:0] f_wp, f_rp;

  logic req_fire, rsp_fire, rsp_live, bypass_hit, dec_fire;
  logic fifo_empty, fifo_push, fifo_pop;

  function automatic logic [PQW-1:0] pq_next(input logic [PQW-1:0] p);
    return (p == PQW'(OUTS - 1)) ? '0 : p + PQW'(1);
  endfunction

  function automatic logic [FPW-1:0] f_next(input logic [FPW-1:0] p);
    return (p == FPW'(DP - 1)) ? '0 : p + FPW'(1);
  endfunction

  assign fifo_empty = (fifo_cnt == '0);

  // Credit: a request is issued only if its response is guaranteed a FIFO
  // slot. Gating with rst makes the valids drop as soon as reset is asserted.
  assign ifu_req_vld  = rst & ~jmp_req_i & (inflight < OUTS_C) &
                        (({1'b0, inflight} + {1'b0, fifo_cnt}) < DP_C);
  assign ifu_req_addr = fetch_pc;
  assign ifu_rsp_rdy  = 1'b1;

  assign req_fire = ifu_req_vld & ifu_req_rdy;
  assign rsp_fire = ifu_rsp_vld;
  // Responses are in order, so a nonzero kill_cnt means the arriving
  // response belongs to a request made before the last redirect.
  assign rsp_live   = rsp_fire & (kill_cnt == '0);
  assign bypass_hit = (BYPASS != 0) & rsp_live & fifo_empty;

  assign ifu_vld_o = rst & ~jmp_req_i & (~fifo_empty | bypass_hit);
  assign dec_fire  = ifu_vld_o & ifu_rdy_i;
  assign fifo_pop  = dec_fire & ~fifo_empty;
  // A bypassed response that decode takes in the same cycle is not stored.
  assign fifo_push = rsp_live & ~jmp_req_i & ~(bypass_hit & dec_fire);

  assign ifu_pc_o    = fifo_empty ? pq_mem[pq_rp] : f_pc[f_rp];
  assign ifu_instr_o = fifo_empty ? ifu_rsp_data  : f_instr[f_rp];
  assign ifu_err_o   = fifo_empty ? ifu_rsp_err   : f_err[f_rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RST_PC;
      inflight <= '0;
      kill_cnt <= '0;
      fifo_cnt <= '0;
      pq_wp    <= '0;
      pq_rp    <= '0;
      f_wp     <= '0;
      f_rp     <= '0;
    end else if (jmp_req_i) begin
      // Every request still owed by memory, old stale ones included, becomes
      // stale. A response arriving in this same cycle is already consumed.
      fetch_pc <= jmp_addr_i;
      inflight <= inflight - CW'(rsp_fire);
      kill_cnt <= inflight - CW'(rsp_fire);
      fifo_cnt <= '0;
      pq_wp    <= '0;
      pq_rp    <= '0;
      f_wp     <= '0;
      f_rp     <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + AW'(4);
        pq_wp    <= pq_next(pq_wp);
      end
      inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire && (kill_cnt != '0)) kill_cnt <= kill_cnt - CW'(1);
      if (rsp_live) pq_rp <= pq_next(pq_rp);
      if (fifo_push) f_wp <= f_next(f_wp);
      if (fifo_pop) f_rp <= f_next(f_rp);
      fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // Storage arrays carry no reset; their contents are qualified by the
  // pointers and counters above.
  always_ff @(posedge clk) begin
    if (req_fire) pq_mem[pq_wp] <= fetch_pc;
    if (fifo_push) begin
      f_pc[f_wp]    <= pq_mem[pq_rp];
      f_instr[f_wp] <= ifu_rsp_data;
      f_err[f_wp]   <= ifu_rsp_err;
    end
  end

  a_inflight_max : assert property (@(posedge clk) disable iff (!rst)
    inflight <= OUTS_C);
  a_kill_le_inflight : assert property (@(posedge clk) disable iff (!rst)
    kill_cnt <= inflight);
  a_credit : assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, inflight} + {1'b0, fifo_cnt}) <= DP_C);

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Testbench for ifu_fetch_queue. The bench plays instruction memory and
// decode. Its reference model tracks outstanding memory requests, a
// redirect epoch, and the ordered list of instructions decode should see.
module tb_ifu_fetch_queue;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OUTS = 2;
  localparam int DP = 4;
  localparam int BYPASS = 1;
  localparam logic [AW-1:0] RST_PC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          jmp_req_i;
  logic [AW-1:0] jmp_addr_i;
  logic          ifu_vld_o;
  logic          ifu_rdy_i;
  logic [AW-1:0] ifu_pc_o;
  logic [DW-1:0] ifu_instr_o;
  logic          ifu_err_o;
  logic          ifu_req_vld;
  logic          ifu_req_rdy;
  logic [AW-1:0] ifu_req_addr;
  logic          ifu_rsp_vld;
  logic          ifu_rsp_rdy;
  logic [DW-1:0] ifu_rsp_data;
  logic          ifu_rsp_err;

  ifu_fetch_queue #(
    .AW(AW), .DW(DW), .OUTS(OUTS), .DP(DP), .BYPASS(BYPASS), .RST_PC(RST_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .jmp_req_i(jmp_req_i), .jmp_addr_i(jmp_addr_i),
    .ifu_vld_o(ifu_vld_o), .ifu_rdy_i(ifu_rdy_i),
    .ifu_pc_o(ifu_pc_o), .ifu_instr_o(ifu_instr_o), .ifu_err_o(ifu_err_o),
    .ifu_req_vld(ifu_req_vld), .ifu_req_rdy(ifu_req_rdy),
    .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_rdy(ifu_rsp_rdy),
    .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          err;
    int            epoch;
    int            due;
  } mreq_t;

  mreq_t               mem_q[$];     // requests owed by memory, in order
  logic [AW+DW:0]      exp_q[$];     // {pc, instr, err} decode should see
  logic [AW-1:0]       exp_addr;     // next fetch address
  int                  epoch = 0;
  int                  arrived = 0;  // returned, current-epoch, not yet taken
  int                  cyc = 0;
  int                  req_count = 0;
  int                  errors = 0;
  int                  checks = 0;
  bit                  run = 1'b0;

  // stimulus knobs (percent probabilities)
  int p_rdy = 100, p_req_rdy = 100, p_rsp = 100, p_jmp = 0, lat_max = 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    exp_q.delete();
    arrived = 0;
    epoch++;
    exp_addr = RST_PC;
  endtask

  // ---------------- driver: memory and decode inputs ----------------
  always @(negedge clk) begin
    cyc++;
    if (run) begin
      ifu_rdy_i   = ($urandom_range(1, 100) <= p_rdy);
      ifu_req_rdy = ($urandom_range(1, 100) <= p_req_rdy);
      jmp_req_i   = ($urandom_range(1, 100) <= p_jmp);
      jmp_addr_i  = $urandom() & 32'hFFFF_FFFC;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
          $urandom_range(1, 100) <= p_rsp) begin
        ifu_rsp_vld  = 1'b1;
        ifu_rsp_data = mem_word(mem_q[0].addr);
        ifu_rsp_err  = mem_q[0].err;
      end else begin
        ifu_rsp_vld  = 1'b0;
        ifu_rsp_data = $urandom();
        ifu_rsp_err  = 1'b0;
      end
    end
  end

  // ---------------- stimulus bookkeeping: push expectations ----------------
  always @(negedge clk) begin
    bit cur_rsp, exp_req_vld, exp_dec_vld, e;
    int d;
    #3;
    if (run) begin
      cur_rsp     = ifu_rsp_vld && mem_q.size() > 0 && mem_q[0].epoch == epoch;
      exp_req_vld = !jmp_req_i && mem_q.size() < OUTS &&
                    (mem_q.size() + arrived) < DP;
      exp_dec_vld = !jmp_req_i && (arrived > 0 || (BYPASS != 0 && cur_rsp));
      chk("req_vld", 64'(ifu_req_vld), 64'(exp_req_vld));
      chk("ifu_vld", 64'(ifu_vld_o), 64'(exp_dec_vld));
      chk("rsp_rdy", 64'(ifu_rsp_rdy), 64'(1));
      if (ifu_req_vld) chk("req_addr", 64'(ifu_req_addr), 64'(exp_addr));
      if (ifu_rsp_vld && mem_q.size() > 0) begin
        if (cur_rsp) arrived++;
        void'(mem_q.pop_front());
      end
      if (jmp_req_i) begin
        exp_q.delete();
        arrived = 0;
        epoch++;
        exp_addr = jmp_addr_i;
      end else if (ifu_req_vld && ifu_req_rdy) begin
        e = ($urandom_range(0, 7) == 0);
        d = cyc + $urandom_range(1, lat_max);
        if (mem_q.size() > 0 && mem_q[$].due > d) d = mem_q[$].due;
        mem_q.push_back('{addr: ifu_req_addr, err: e, epoch: epoch, due: d});
        exp_q.push_back({ifu_req_addr, mem_word(ifu_req_addr), e});
        exp_addr = exp_addr + 32'd4;
        req_count++;
      end
    end
  end

  // ---------------- monitor / scoreboard: pop and compare ----------------
  always @(negedge clk) begin
    logic [AW+DW:0] ent;
    #4;
    if (run && ifu_vld_o && ifu_rdy_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dec_unexpected: got pc %h with nothing expected at t=%0t",
                 ifu_pc_o, $time);
      end else begin
        ent = exp_q.pop_front();
        chk("dec_pc", 64'(ifu_pc_o), 64'(ent[AW+DW:DW+1]));
        chk("dec_instr", 64'(ifu_instr_o), 64'(ent[DW:1]));
        chk("dec_err", 64'(ifu_err_o), 64'(ent[0]));
        arrived--;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int base;
    rst = 1'b0;
    jmp_req_i = 1'b0;
    jmp_addr_i = '0;
    ifu_rdy_i = 1'b0;
    ifu_req_rdy = 1'b0;
    ifu_rsp_vld = 1'b1;
    ifu_rsp_data = 32'h0000_0013;
    ifu_rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_vld", 64'(ifu_req_vld), 64'(0));
    chk("rst_ifu_vld", 64'(ifu_vld_o), 64'(0));
    chk("rst_rsp_rdy", 64'(ifu_rsp_rdy), 64'(1));

    @(negedge clk);
    ifu_rsp_vld = 1'b0;
    model_reset();
    rst = 1'b1;
    run = 1'b1;

    // streaming: everything ready, single-cycle memory
    repeat (30) @(negedge clk);

    // drain, then hold decode off: exactly DP requests must issue
    p_req_rdy = 0;
    repeat (10) @(negedge clk);
    base = req_count;
    p_req_rdy = 100;
    p_rdy = 0;
    repeat (20) @(negedge clk);
    chk("backpressure_reqs", 64'(req_count - base), 64'(DP));
    p_rdy = 100;
    repeat (20) @(negedge clk);

    // random traffic with redirects and variable latency
    p_rdy = 70; p_req_rdy = 70; p_rsp = 70; p_jmp = 8; lat_max = 3;
    repeat (600) @(negedge clk);
    p_jmp = 25; lat_max = 2; p_rsp = 100;
    repeat (200) @(negedge clk);

    // back to streaming, then asynchronous reset mid-stream
    p_rdy = 100; p_req_rdy = 100; p_rsp = 100; p_jmp = 0; lat_max = 1;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2;
    run = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_ifu_vld", 64'(ifu_vld_o), 64'(0));
    chk("async_rst_req_vld", 64'(ifu_req_vld), 64'(0));
    ifu_rsp_vld = 1'b1;
    jmp_req_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("in_rst_ifu_vld", 64'(ifu_vld_o), 64'(0));
    @(negedge clk);
    ifu_rsp_vld = 1'b0;
    model_reset();
    rst = 1'b1;
    run = 1'b1;
    repeat (40) @(negedge clk);

    run = 1'b0;
    #10;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Parametrised successor to the single-entry instruction-fetch front end.
- Issues sequential fetch requests to instruction memory, with up to OUTS requests in flight, and buffers responses in a DP-deep FIFO together with their PCs.
- On a redirect it flushes all state and discards stale in-flight responses using a kill counter.
- Sits between the memory/bus instruction port and the decode stage.
- Optional same-cycle bypass when the FIFO is empty.

Parameters:
- AW, 32, address width.
- DW, 32, instruction/data width.
- OUTS, 2, maximum outstanding memory requests (>=1).
- DP, 4, response FIFO depth (>=OUTS; power of two).
- BYPASS, 1, 1 = a response arriving into an empty FIFO is presented to decode in the same cycle.
- RST_PC, 32'h8000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- jmp_req_i  in  1  redirect request (one-cycle pulse or level).
- jmp_addr_i  in  AW  redirect target.
- ifu_vld_o  out  1  instruction valid to decode.
- ifu_rdy_i  in  1  decode ready.
- ifu_pc_o  out  AW  PC of presented instruction.
- ifu_instr_o  out  DW  presented instruction.
- ifu_err_o  out  1  bus error for presented instruction.
- ifu_req_vld  out  1  memory request valid.
- ifu_req_rdy  in  1  memory request ready.
- ifu_req_addr  out  AW  memory request address.
- ifu_rsp_vld  in  1  memory response valid.
- ifu_rsp_rdy  out  1  memory response ready.
- ifu_rsp_data  in  DW  memory response data.
- ifu_rsp_err  in  1  memory response error.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-low. All state clears on rst=0 regardless of clk.
- Reset values:
  - fetch_pc = RST_PC; inflight = 0; kill_cnt = 0; FIFO empty; PC queue empty.
  - Outputs: ifu_vld_o = 0, ifu_req_vld = 0 during reset, ifu_rsp_rdy = 1; data outputs are don't-care.
- Request side:
  - ifu_req_addr = fetch_pc.
  - ifu_req_vld = ~jmp_req_i & (inflight < OUTS) & (inflight + fifo_cnt < DP).
  - On req handshake: push fetch_pc into the PC queue (depth OUTS), fetch_pc += 4 (mod 2^AW), inflight += 1.
- Response side:
  - ifu_rsp_rdy is constant 1. The credit rule guarantees space.
  - Responses are in order.
  - On a response handshake with kill_cnt>0: drop it, kill_cnt -= 1, inflight -= 1.
  - Otherwise: pop the PC queue and push {pc,data,err} into the FIFO, inflight -= 1.
  - Request and response in the same cycle: inflight is unchanged.
- Decode side:
  - ifu_vld_o = (fifo_cnt>0 | bypass_hit) & ~jmp_req_i. Head entry drives pc/instr/err.
  - Pop on ifu_vld_o & ifu_rdy_i.
  - Latency: response at cycle T is visible at T+1 (BYPASS=0).
  - With BYPASS=1: visible at T when the FIFO is empty and kill_cnt==0. If decode accepts in T, nothing is stored; otherwise it is stored.
  - Simultaneous push and pop on a full FIFO cannot occur, because credit prevents full+push.
- Redirect (jmp_req_i=1 in cycle T):
  - No request issued, no decode handshake.
  - At the edge: fetch_pc <= jmp_addr_i; FIFO and PC queue cleared.
  - kill_cnt <= inflight - (response handshake in T ? 1 : 0), plus any existing kill_cnt already folded into inflight.
  - Fetch from the target starts at T+1.
  - Back-to-back redirects: the last target wins; kill_cnt tracks all stale requests.
- Errors: an err response is passed through unchanged; fetch continues sequentially. Decode/trap logic owns the redirect.
- Invariants for assertions:
  - inflight <= OUTS.
  - kill_cnt <= inflight.
  - fifo_cnt + inflight <= DP.
  - The PC queue occupancy equals inflight - kill_cnt.

Test Plan:
- Streaming: reset, memory always ready, 1-cycle response latency, decode always ready -> req addrs 8000_0000, _0004, _0008... back-to-back; decode receives matching PC/instr with no gaps after the first.
- Backpressure: OUTS=2, DP=4, decode rdy=0 -> exactly 4 requests issue, then ifu_req_vld=0; raising rdy drains in order 8000_0000.._000C, and fetching resumes at 8000_0010.
- Redirect with 2 in flight: jmp_req_i with addr 0000_1000 while 2 requests are outstanding -> both returning responses dropped (kill_cnt 2->1->0); first decoded PC = 0000_1000; ifu_vld_o=0 in the redirect cycle.
- Redirect coinciding with a response in the same cycle -> kill_cnt=1, only one later response dropped; FIFO empty at T+1.
- Bypass: BYPASS=1, FIFO empty, response data 0x0000_0013 at cycle T -> ifu_vld_o=1 with instr 0x13 in T; BYPASS=0 -> first valid at T+1.
- Error and reset: response with err=1 at PC 8000_0008 -> ifu_err_o=1 for that entry only. Async rst low mid-stream -> ifu_vld_o and ifu_req_vld drop immediately; after release, fetch restarts at 8000_0000.
